// File: rtl/baud_nco_gen.sv
// Fractional (NCO) baud tick generator: oversampled tick plus mid-bit and bit-boundary strobes.
// Optional BAUD_NCO_SHADOW_EN defers increment updates to the next bit boundary.
module baud_nco_gen #(
    parameter int ACC_WIDTH   = 16,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_INC = 839
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic                 i_resync,
    input  logic [ACC_WIDTH-1:0] i_cfg_inc,
    input  logic                 i_cfg_valid,
    output logic                 o_cfg_pending,
    output logic                 o_os_tick,
    output logic                 o_mid_tick,
    output logic                 o_bit_tick
);

    localparam int                   CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]     CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [ACC_WIDTH-1:0] INC_RST  = ACC_WIDTH'(DEFAULT_INC);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_inc_q;
    logic [CNT_W-1:0]     r_os_cnt;
    logic                 r_os_tick;
    logic                 r_mid_tick;
    logic                 r_bit_tick;

    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_run;
    logic                 w_carry;
    logic                 w_at_last;
    logic                 w_at_mid;
    logic                 w_bit_gen;

    // resync and disable both override the carry, so ticks only come from a running accumulator
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_inc_q};
    assign w_run     = i_enable & ~i_resync;
    assign w_carry   = w_run & w_sum[ACC_WIDTH];
    assign w_at_last = (r_os_cnt == CNT_LAST);
    assign w_at_mid  = (r_os_cnt == CNT_MID);
    assign w_bit_gen = w_carry & w_at_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc      <= '0;
            r_os_cnt   <= '0;
            r_os_tick  <= 1'b0;
            r_mid_tick <= 1'b0;
            r_bit_tick <= 1'b0;
        end else if (!w_run) begin
            r_acc      <= '0;
            r_os_cnt   <= '0;
            r_os_tick  <= 1'b0;
            r_mid_tick <= 1'b0;
            r_bit_tick <= 1'b0;
        end else begin
            r_acc      <= w_sum[ACC_WIDTH-1:0];
            r_os_tick  <= w_carry;
            r_mid_tick <= w_carry & w_at_mid;
            r_bit_tick <= w_bit_gen;
            if (w_carry) begin
                r_os_cnt <= w_at_last ? '0 : r_os_cnt + CNT_W'(1);
            end
        end
    end

`ifdef BAUD_NCO_SHADOW_EN
    logic [ACC_WIDTH-1:0] r_shadow;
    logic                 r_pending;
    logic                 w_xfer;

    // a cfg_valid coinciding with the transfer refills the shadow and keeps pending set
    assign w_xfer = r_pending & (w_bit_gen | ~i_enable);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inc_q   <= INC_RST;
            r_shadow  <= INC_RST;
            r_pending <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_inc_q <= r_shadow;
            end
            if (i_cfg_valid) begin
                r_shadow  <= i_cfg_inc;
                r_pending <= 1'b1;
            end else if (w_xfer) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_cfg_pending = r_pending;
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inc_q <= INC_RST;
        end else if (i_cfg_valid) begin
            r_inc_q <= i_cfg_inc;
        end
    end

    assign o_cfg_pending = 1'b0;
`endif

    assign o_os_tick  = r_os_tick;
    assign o_mid_tick = r_mid_tick;
    assign o_bit_tick = r_bit_tick;

endmodule

// File: tb/tb_baud_nco_gen.sv
// Directed bench for baud_nco_gen at ACC_WIDTH=8, OVERSAMPLE=4, DEFAULT_INC=64.
// Covers both builds; the increment-update scenario follows BAUD_NCO_SHADOW_EN.
module tb_baud_nco_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       resync = 1'b0;
    logic [7:0] cfg_inc = 8'd0;
    logic       cfg_valid = 1'b0;
    logic       cfg_pending;
    logic       os_tick;
    logic       mid_tick;
    logic       bit_tick;

    int n_tests = 0;
    int n_fail  = 0;

    baud_nco_gen #(
        .ACC_WIDTH  (8),
        .OVERSAMPLE (4),
        .DEFAULT_INC(64)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (enable),
        .i_resync     (resync),
        .i_cfg_inc    (cfg_inc),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_pending(cfg_pending),
        .o_os_tick    (os_tick),
        .o_mid_tick   (mid_tick),
        .o_bit_tick   (bit_tick)
    );

    always #5 clk = ~clk;

    // advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable    = 1'b0;
        resync    = 1'b0;
        cfg_valid = 1'b0;
        cfg_inc   = 8'd0;
        rst       = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_tests++;
        if ({os_tick, mid_tick, bit_tick, cfg_pending} !== 4'b0000) begin
            $display("FAIL reset_hold: got %b want 0000", {os_tick, mid_tick, bit_tick, cfg_pending});
            n_fail++;
        end
        do_reset();
        n_tests++;
        if ({os_tick, mid_tick, bit_tick, cfg_pending} !== 4'b0000) begin
            $display("FAIL reset_release: got %b want 0000", {os_tick, mid_tick, bit_tick, cfg_pending});
            n_fail++;
        end
    endtask

    // inc=64: tick every 4 cycles, mid at tick 2 of each bit, bit at tick 4
    task automatic test_default_rate();
        do_reset();
        enable = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            n_tests++;
            if ({os_tick, mid_tick, bit_tick} !== {n % 4 == 0, n % 16 == 8, n % 16 == 0}) begin
                $display("FAIL default_rate cycle %0d: got os/mid/bit %b want %b", n,
                         {os_tick, mid_tick, bit_tick}, {n % 4 == 0, n % 16 == 8, n % 16 == 0});
                n_fail++;
            end
        end
    endtask

    // inc=96: exact phase n*96 mod 256 gives spacings 3,3,2 with no drift
    task automatic test_fractional();
        int k;
        int kp;
        logic e_os;
        logic e_mid;
        logic e_bit;
        do_reset();
        cfg_inc   = 8'd96;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        step();
        n_tests++;
        if (cfg_pending !== 1'b0) begin
            $display("FAIL frac_pending_idle: got %b want 0", cfg_pending);
            n_fail++;
        end
        enable = 1'b1;
        for (int n = 1; n <= 1000; n++) begin
            step();
            k     = (96 * n) / 256;
            kp    = (96 * (n - 1)) / 256;
            e_os  = (k != kp);
            e_mid = e_os && (k % 4 == 2);
            e_bit = e_os && (k % 4 == 0);
            n_tests++;
            if ({os_tick, mid_tick, bit_tick} !== {e_os, e_mid, e_bit}) begin
                $display("FAIL fractional cycle %0d: got os/mid/bit %b want %b", n,
                         {os_tick, mid_tick, bit_tick}, {e_os, e_mid, e_bit});
                n_fail++;
            end
        end
    endtask

    // resync on the edge that would carry with os_cnt=2
    task automatic test_resync();
        do_reset();
        enable = 1'b1;
        for (int n = 1; n <= 11; n++) step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        n_tests++;
        if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin
            $display("FAIL resync_cycle: got os/mid/bit %b want 000", {os_tick, mid_tick, bit_tick});
            n_fail++;
        end
        for (int n = 1; n <= 20; n++) begin
            step();
            n_tests++;
            if ({os_tick, mid_tick, bit_tick} !== {n % 4 == 0, n % 16 == 8, n % 16 == 0}) begin
                $display("FAIL resync_after cycle %0d: got os/mid/bit %b want %b", n,
                         {os_tick, mid_tick, bit_tick}, {n % 4 == 0, n % 16 == 8, n % 16 == 0});
                n_fail++;
            end
        end
    endtask

    task automatic test_enable_gap();
        do_reset();
        enable = 1'b1;
        for (int n = 1; n <= 6; n++) step();
        enable = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            step();
            n_tests++;
            if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin
                $display("FAIL enable_low cycle %0d: got os/mid/bit %b want 000", n,
                         {os_tick, mid_tick, bit_tick});
                n_fail++;
            end
        end
        enable = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            n_tests++;
            if ({os_tick, mid_tick, bit_tick} !== {n % 4 == 0, n % 16 == 8, n % 16 == 0}) begin
                $display("FAIL enable_restart cycle %0d: got os/mid/bit %b want %b", n,
                         {os_tick, mid_tick, bit_tick}, {n % 4 == 0, n % 16 == 8, n % 16 == 0});
                n_fail++;
            end
        end
    endtask

    // cfg_inc=128 issued on cycle 5 (os_cnt=1), then async reset mid-bit
    task automatic test_cfg_update();
        logic e_os;
        logic e_mid;
        logic e_bit;
        logic e_pend;
        do_reset();
        enable = 1'b1;
        for (int n = 1; n <= 4; n++) step();
        for (int n = 5; n <= 24; n++) begin
            cfg_valid = (n == 5);
            cfg_inc   = 8'd128;
            step();
            cfg_valid = 1'b0;
`ifdef BAUD_NCO_SHADOW_EN
            e_os   = (n == 8) || (n == 12) || (n == 16) || (n >= 18 && n % 2 == 0);
            e_mid  = (n == 8) || (n == 20);
            e_bit  = (n == 16) || (n == 24);
            e_pend = (n >= 5) && (n < 16);
`else
            e_os   = (n >= 7) && (n % 2 == 1);
            e_mid  = (n % 8 == 7);
            e_bit  = (n >= 11) && (n % 8 == 3);
            e_pend = 1'b0;
`endif
            n_tests++;
            if ({os_tick, mid_tick, bit_tick, cfg_pending} !== {e_os, e_mid, e_bit, e_pend}) begin
                $display("FAIL cfg_update cycle %0d: got os/mid/bit/pend %b want %b", n,
                         {os_tick, mid_tick, bit_tick, cfg_pending}, {e_os, e_mid, e_bit, e_pend});
                n_fail++;
            end
        end
        for (int i = 0; i < 4 && os_tick !== 1'b1; i++) step();
        n_tests++;
        if (os_tick !== 1'b1) begin
            $display("FAIL async_rst_precond: got os_tick %b want 1", os_tick);
            n_fail++;
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({os_tick, mid_tick, bit_tick, cfg_pending} !== 4'b0000) begin
            $display("FAIL async_rst: got %b want 0000", {os_tick, mid_tick, bit_tick, cfg_pending});
            n_fail++;
        end
        step();
        rst    = 1'b0;
        enable = 1'b0;
        step();
    endtask

    task automatic test_zero_inc();
        int ticks;
        do_reset();
        cfg_inc   = 8'd0;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        step();
        enable = 1'b1;
        ticks  = 0;
        for (int n = 1; n <= 600; n++) begin
            step();
            if (os_tick === 1'b1) ticks++;
        end
        n_tests++;
        if (ticks !== 0) begin
            $display("FAIL zero_inc: got %0d ticks want 0", ticks);
            n_fail++;
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_rate();
        test_fractional();
        test_resync();
        test_enable_gap();
        test_cfg_update();
        test_zero_inc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
